mul_issue_ctrl: RTL and testbench

- Sits in the EXE stage between the pipeline's multiply instruction issue and the 2-stage Booth/Wallace multiplier (`mul`).
- Accepts one MUL.W / MULH.W / MULH.WU per cycle and drives the multiplier's x, y and mul_signed inputs.
- Tracks the in-flight operation through the multiplier's single internal register stage, selects the correct 32-bit half of the 64-bit product, and buffers it in a 2-entry result queue toward MEM.
- Provides full valid/ready backpressure and pipeline flush.

---
 rtl/mul_issue_ctrl.sv | 115 +++++++++++
 tb/tb_mul_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue control for the 2-stage multiplier: drives the operands, selects the product half, and queues results.
// Optional MUL_STAT_CNT_EN adds a stat_cnt output that counts result pops.
module mul_issue_ctrl #(
    parameter int TAG_W  = 5,
    parameter int QDEPTH = 2
) (
    input  logic             mul_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    output logic             mul_signed,
    output logic             mul_resetn,
    input  logic [63:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef MUL_STAT_CNT_EN
    ,
    output logic [31:0]      stat_cnt
`endif
);

    logic                       s1_valid_q, s1_valid_d;
    logic [1:0]                 s1_op_q, s1_op_d;
    logic [TAG_W-1:0]           s1_tag_q, s1_tag_d;
    logic [1:0][31:0]           q_data_q, q_data_d;
    logic [1:0][TAG_W-1:0]      q_tag_q, q_tag_d;
    logic [1:0]                 q_cnt_q, q_cnt_d;
    logic [1:0]                 cnt_after;
    logic [2:0]                 occ;
    logic                       fire, pop, push;
    logic [31:0]                sel_data;

    assign mul_resetn = ~reset;
    assign out_valid  = (q_cnt_q != 2'd0);
    assign out_data   = q_data_q[0];
    assign out_tag    = q_tag_q[0];

    always_comb begin
        pop      = out_valid && out_ready;
        push     = s1_valid_q;
        // Ready counts the slot freed by this cycle's pop, so S1 never finds the queue full.
        occ      = {2'b00, s1_valid_q} + {1'b0, q_cnt_q};
        in_ready = (occ - {2'b00, pop}) < 3'(QDEPTH);
        fire     = in_valid && in_ready && !flush && !reset;

        mul_x      = fire ? in_src1 : 32'd0;
        mul_y      = fire ? in_src2 : 32'd0;
        mul_signed = fire && (in_op == 2'b01);

        sel_data = (s1_op_q == 2'b01 || s1_op_q == 2'b10) ? mul_result[63:32] : mul_result[31:0];

        s1_valid_d = fire;
        s1_op_d    = fire ? in_op  : s1_op_q;
        s1_tag_d   = fire ? in_tag : s1_tag_q;
        q_data_d   = q_data_q;
        q_tag_d    = q_tag_q;
        q_cnt_d    = q_cnt_q;
        cnt_after  = q_cnt_q - {1'b0, pop};

        if (flush) begin
            q_cnt_d = 2'd0;
        end else begin
            if (pop) begin
                q_data_d[0] = q_data_q[1];
                q_tag_d[0]  = q_tag_q[1];
            end
            if (push) begin
                q_data_d[cnt_after[0]] = sel_data;
                q_tag_d[cnt_after[0]]  = s1_tag_q;
            end
            q_cnt_d = cnt_after + {1'b0, push};
        end
    end

    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 2'b00;
            s1_tag_q   <= '0;
            q_data_q   <= '0;
            q_tag_q    <= '0;
            q_cnt_q    <= 2'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            q_data_q   <= q_data_d;
            q_tag_q    <= q_tag_d;
            q_cnt_q    <= q_cnt_d;
        end
    end

`ifdef MUL_STAT_CNT_EN
    logic [31:0] stat_cnt_q, stat_cnt_d;

    always_comb stat_cnt_d = stat_cnt_q + {31'd0, pop};

    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) stat_cnt_q <= 32'd0;
        else       stat_cnt_q <= stat_cnt_d;
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural 2-stage multiplier alongside.
module tb_mul_issue_ctrl;
    localparam int TAG_W = 5;

    logic             mul_clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, flush;
    logic [1:0]       in_op;
    logic [31:0]      in_src1, in_src2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      mul_x, mul_y;
    logic             mul_signed, mul_resetn;
    logic [63:0]      mul_result;
    logic             out_valid, out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef MUL_STAT_CNT_EN
    logic [31:0]      stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [1:0]       v_op  [16];
    logic [31:0]      v_a   [16];
    logic [31:0]      v_b   [16];
    logic [31:0]      v_exp [16];
    logic [TAG_W-1:0] v_tag [16];

    mul_issue_ctrl #(.TAG_W(TAG_W), .QDEPTH(2)) dut (
        .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .flush(flush), .mul_x(mul_x), .mul_y(mul_y), .mul_signed(mul_signed),
        .mul_resetn(mul_resetn), .mul_result(mul_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef MUL_STAT_CNT_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    always #5 mul_clk = ~mul_clk;

    function automatic logic [63:0] ext(input logic [31:0] v, input logic s);
        return {{32{s & v[31]}}, v};
    endfunction

    // Multiplier: one register stage, product valid the cycle after operands are presented.
    always_ff @(posedge mul_clk or negedge mul_resetn) begin
        if (!mul_resetn) mul_result <= 64'd0;
        else             mul_result <= ext(mul_x, mul_signed) * ext(mul_y, mul_signed);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = t;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_src1  = 32'd0;
        in_src2  = 32'd0;
        in_tag   = '0;
    endtask

    // Issues n ops back-to-back; each result must appear two edges after its accept.
    task automatic stream(input int n);
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                drive(v_op[c], v_a[c], v_b[c], v_tag[c]);
                #1;
                chk("stream_in_ready", in_ready, 1'b1);
                chk("stream_mul_signed", mul_signed, v_op[c] == 2'b01);
            end else begin
                idle();
            end
            cyc();
            if (c >= 1) begin
                chk("stream_out_valid", out_valid, 1'b1);
                chk("stream_out_data", out_data, v_exp[c-1]);
                chk("stream_out_tag", out_tag, v_tag[c-1]);
            end
        end
        idle();
        cyc();
        chk("stream_drained", out_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle();

        // Reset state, including operand gating while reset is held
        #2;
        drive(2'b01, 32'd5, 32'd6, 5'd1);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_mul_x", mul_x, 32'd0);
        chk("rst_mul_y", mul_y, 32'd0);
        chk("rst_mul_signed", mul_signed, 1'b0);
        chk("rst_mul_resetn", mul_resetn, 1'b0);
        idle();
        @(negedge mul_clk);
        reset = 1'b0;
        cyc();

        // MUL.W 7 * -3, latency of two edges
        drive(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3);
        #1;
        chk("t1_mul_x", mul_x, 32'd7);
        chk("t1_mul_y", mul_y, 32'hFFFF_FFFD);
        chk("t1_mul_signed", mul_signed, 1'b0);
        cyc();
        idle();
        chk("t1_not_early", out_valid, 1'b0);
        cyc();
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_data", out_data, 32'hFFFF_FFEB);
        chk("t1_out_tag", out_tag, 5'd3);
        cyc();
        chk("t1_popped", out_valid, 1'b0);

        // High-half selects and the reserved opcode
        v_op[0] = 2'b01; v_a[0] = 32'h8000_0000; v_b[0] = 32'h8000_0000; v_exp[0] = 32'h4000_0000; v_tag[0] = 5'd4;
        v_op[1] = 2'b10; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF; v_exp[1] = 32'hFFFF_FFFE; v_tag[1] = 5'd5;
        v_op[2] = 2'b01; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'hFFFF_FFFF; v_exp[2] = 32'h0000_0000; v_tag[2] = 5'd6;
        v_op[3] = 2'b11; v_a[3] = 32'h1000_0001; v_b[3] = 32'd5;         v_exp[3] = 32'h5000_0005; v_tag[3] = 5'd7;
        stream(4);

        // Backpressure: third op waits until the consumer drains
        out_ready = 1'b0;
        drive(2'b00, 32'd10, 32'd10, 5'd10);
        cyc();
        drive(2'b00, 32'd11, 32'd11, 5'd11);
        #1;
        chk("bp_ready_2nd", in_ready, 1'b1);
        cyc();
        drive(2'b00, 32'd12, 32'd12, 5'd12);
        #1;
        chk("bp_ready_low", in_ready, 1'b0);
        cyc();
        chk("bp_head", out_data, 32'd100);
        chk("bp_ready_full", in_ready, 1'b0);
        cyc();
        chk("bp_head_stable", out_data, 32'd100);
        chk("bp_tag_stable", out_tag, 5'd10);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_on_pop", in_ready, 1'b1);
        cyc();
        idle();
        chk("bp_second", out_data, 32'd121);
        chk("bp_second_tag", out_tag, 5'd11);
        cyc();
        chk("bp_third", out_data, 32'd144);
        chk("bp_third_tag", out_tag, 5'd12);
        cyc();
        chk("bp_drained", out_valid, 1'b0);

        // Full-rate stream of 16 ops
        for (int i = 0; i < 16; i++) begin
            v_op[i]  = 2'b00;
            v_a[i]   = 32'(i + 2);
            v_b[i]   = 32'(i * 17 + 1);
            v_exp[i] = 32'((i + 2) * (i * 17 + 1));
            v_tag[i] = 5'(i + 16);
        end
        stream(16);

        // Flush while the first op sits in S1; the concurrent issue is refused
        drive(2'b00, 32'd2, 32'd3, 5'd1);
        cyc();
        drive(2'b00, 32'd4, 32'd5, 5'd2);
        flush = 1'b1;
        #1;
        chk("fl_no_fire", mul_x, 32'd0);
        cyc();
        flush = 1'b0;
        idle();
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        drive(2'b00, 32'd6, 32'd7, 5'd4);
        cyc();
        idle();
        chk("fl_no_ghost", out_valid, 1'b0);
        cyc();
        chk("fl_new_valid", out_valid, 1'b1);
        chk("fl_new_data", out_data, 32'd42);
        chk("fl_new_tag", out_tag, 5'd4);
        cyc();
        chk("fl_new_popped", out_valid, 1'b0);

        // Flush with a full queue
        out_ready = 1'b0;
        drive(2'b00, 32'd1, 32'd1, 5'd5);
        cyc();
        drive(2'b00, 32'd2, 32'd2, 5'd6);
        cyc();
        idle();
        cyc();
        chk("flq_full_valid", out_valid, 1'b1);
        chk("flq_full_ready", in_ready, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flq_empty", out_valid, 1'b0);
        chk("flq_ready", in_ready, 1'b1);
        cyc();
        chk("flq_still_empty", out_valid, 1'b0);

        // Asynchronous reset with two results queued
        drive(2'b01, 32'd9, 32'd9, 5'd7);
        cyc();
        drive(2'b00, 32'd8, 32'd8, 5'd8);
        cyc();
        idle();
        cyc();
        chk("ar_queued", out_data, 32'd0);
        chk("ar_queued_tag", out_tag, 5'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_out_data", out_data, 32'd0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_mul_resetn", mul_resetn, 1'b0);
`ifdef MUL_STAT_CNT_EN
        chk("ar_stat_cnt", stat_cnt, 32'd0);
`endif
        @(negedge mul_clk);
        reset = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("ar_after_empty", out_valid, 1'b0);
        drive(2'b00, 32'd3, 32'd5, 5'd9);
        cyc();
        idle();
        cyc();
        chk("ar_new_valid", out_valid, 1'b1);
        chk("ar_new_data", out_data, 32'd15);
        chk("ar_new_tag", out_tag, 5'd9);
`ifdef MUL_STAT_CNT_EN
        chk("ar_stat_before_pop", stat_cnt, 32'd0);
`endif
        cyc();
        chk("ar_new_popped", out_valid, 1'b0);
`ifdef MUL_STAT_CNT_EN
        chk("ar_stat_after_pop", stat_cnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
